// File: rtl/vga_pkg.sv
// Shared constants, capture FSM state type and the bit-serial CRC-16-CCITT step
// used by the VGA frame capture block.
package vga_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;
  localparam int FB_AW        = 19;

  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

  localparam logic [10:0] COL_MAX   = 11'd2047;
  localparam logic [9:0]  ROW_GUARD = 10'd512;

  typedef enum logic [1:0] {
    CAP_IDLE,
    CAP_ARMED,
    CAP_CAPTURE,
    CAP_DONE
  } capture_state_t;

  // One MSB-first CRC-16-CCITT step for a single input bit.
  function automatic logic [15:0] crc16_ccitt_bit(input logic [15:0] crc, input logic din);
    logic fb;
    fb = crc[15] ^ din;
    return {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/vga_frame_capture_sync_edge.sv
// Registers hsync/vsync/video_on once, normalises sync polarity and produces
// single-cycle edge strobes from the registered and previous-registered values.
module vga_sync_edge #(
  parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
  input  logic pixel_clk,
  input  logic wb_rst_i,
  input  logic hsync,
  input  logic vsync,
  input  logic video_on,
  output logic video_act,
  output logic hsync_rise,
  output logic vsync_rise,
  output logic video_fall
);

  localparam int N_SIG = 3;

  logic [N_SIG-1:0] raw;
  logic [N_SIG-1:0] s1;
  logic [N_SIG-1:0] prev;

  // bit 0 = hsync_act, bit 1 = vsync_act, bit 2 = video_on
  assign raw = {video_on, vsync ^ SYNC_ACTIVE_LOW, hsync ^ SYNC_ACTIVE_LOW};

  generate
    for (genvar gi = 0; gi < N_SIG; gi++) begin : g_sig
      logic s1_reg;
      logic prev_reg;

      always_ff @(posedge pixel_clk or posedge wb_rst_i) begin
        if (wb_rst_i) begin
          s1_reg   <= 1'b0;
          prev_reg <= 1'b0;
        end else begin
          s1_reg   <= raw[gi];
          prev_reg <= s1_reg;
        end
      end

      assign s1[gi]   = s1_reg;
      assign prev[gi] = prev_reg;
    end
  endgenerate

  assign video_act  = s1[2];
  assign hsync_rise = s1[0] & ~prev[0];
  assign vsync_rise = s1[1] & ~prev[1];
  assign video_fall = ~s1[2] & prev[2];

endmodule

// File: rtl/vga_frame_capture.sv
// Captures one VGA frame as 1 bit per pixel into a framebuffer write port.
// Optional CRC over the captured bits: define VGA_FRAME_CAPTURE_CRC_EN.
module vga_frame_capture
  import vga_pkg::*;
#(
  parameter int H_ACTIVE        = H_ACTIVE_DEF,
  parameter int V_ACTIVE        = V_ACTIVE_DEF,
  parameter int RGB_DEPTH       = 8,
  parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
  input  logic                   pixel_clk,
  input  logic                   wb_rst_i,
  input  logic                   capture_start,
  input  logic                   hsync,
  input  logic                   vsync,
  input  logic                   video_on,
  input  logic [RGB_DEPTH-1:0]   red,
  input  logic [RGB_DEPTH-1:0]   green,
  input  logic [RGB_DEPTH-1:0]   blue,
  input  logic [3*RGB_DEPTH-1:0] fg_color,
  output logic                   fb_we,
  output logic [18:0]            fb_waddr,
  output logic                   fb_wdata,
  output logic                   busy,
  output logic                   done,
  output logic                   frame_error,
  output logic [10:0]            meas_width,
  output logic [9:0]             meas_height,
  output logic [15:0]            crc_o
);

  localparam logic [10:0]      H_ACT_W = 11'(H_ACTIVE);
  localparam logic [9:0]       V_ACT_H = 10'(V_ACTIVE);
  localparam logic [FB_AW-1:0] H_ACT_A = FB_AW'(H_ACTIVE);

  logic video_act;
  logic hsync_rise;
  logic vsync_rise;
  logic video_fall;

  vga_sync_edge #(
    .SYNC_ACTIVE_LOW(SYNC_ACTIVE_LOW)
  ) u_sync_edge (
    .pixel_clk (pixel_clk),
    .wb_rst_i  (wb_rst_i),
    .hsync     (hsync),
    .vsync     (vsync),
    .video_on  (video_on),
    .video_act (video_act),
    .hsync_rise(hsync_rise),
    .vsync_rise(vsync_rise),
    .video_fall(video_fall)
  );

  logic [3*RGB_DEPTH-1:0] rgb_s1_reg;
  logic                   pixel_bit;

  always_ff @(posedge pixel_clk or posedge wb_rst_i) begin
    if (wb_rst_i) rgb_s1_reg <= '0;
    else          rgb_s1_reg <= {red, green, blue};
  end

  assign pixel_bit = (rgb_s1_reg == fg_color);

  capture_state_t   state_reg, state_next;
  logic [10:0]      col_reg, col_next;
  logic [9:0]       row_reg, row_next;
  logic [FB_AW-1:0] line_base_reg, line_base_next;
  logic             fb_we_reg, fb_we_next;
  logic [FB_AW-1:0] fb_waddr_reg, fb_waddr_next;
  logic             fb_wdata_reg, fb_wdata_next;
  logic             frame_error_reg, frame_error_next;
  logic [10:0]      meas_width_reg, meas_width_next;
  logic [9:0]       meas_height_reg, meas_height_next;

  always_comb begin
    state_next       = state_reg;
    col_next         = col_reg;
    row_next         = row_reg;
    line_base_next   = line_base_reg;
    fb_we_next       = 1'b0;
    fb_waddr_next    = fb_waddr_reg;
    fb_wdata_next    = fb_wdata_reg;
    frame_error_next = frame_error_reg;
    meas_width_next  = meas_width_reg;
    meas_height_next = meas_height_reg;

    case (state_reg)
      CAP_IDLE: begin
        if (capture_start) begin
          state_next       = CAP_ARMED;
          frame_error_next = 1'b0;
          meas_width_next  = '0;
          meas_height_next = '0;
        end
      end

      CAP_ARMED: begin
        if (vsync_rise) begin
          state_next     = CAP_CAPTURE;
          col_next       = '0;
          row_next       = '0;
          line_base_next = '0;
        end
      end

      CAP_CAPTURE: begin
        if (video_act) begin
          if (col_reg < H_ACT_W && row_reg < V_ACT_H) begin
            fb_we_next    = 1'b1;
            fb_waddr_next = line_base_reg + FB_AW'(col_reg);
            fb_wdata_next = pixel_bit;
          end else begin
            frame_error_next = 1'b1;
          end
          if (col_reg != COL_MAX) col_next = col_reg + 11'd1;
        end

        if (hsync_rise && video_act) frame_error_next = 1'b1;

        if (video_fall) begin
          meas_width_next  = col_reg;
          if (col_reg != H_ACT_W) frame_error_next = 1'b1;
          row_next         = row_reg + 10'd1;
          meas_height_next = row_reg + 10'd1;
          col_next         = '0;
          line_base_next   = line_base_reg + H_ACT_A;
        end

        // The height check sees the count already advanced by a coincident line end.
        if (vsync_rise) begin
          if (meas_height_next != V_ACT_H) frame_error_next = 1'b1;
          state_next = CAP_DONE;
        end else if (row_next == ROW_GUARD) begin
          frame_error_next = 1'b1;
          state_next       = CAP_DONE;
        end
      end

      CAP_DONE: state_next = CAP_IDLE;

      default: state_next = CAP_IDLE;
    endcase
  end

  always_ff @(posedge pixel_clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_reg       <= CAP_IDLE;
      col_reg         <= '0;
      row_reg         <= '0;
      line_base_reg   <= '0;
      fb_we_reg       <= 1'b0;
      fb_waddr_reg    <= '0;
      fb_wdata_reg    <= 1'b0;
      frame_error_reg <= 1'b0;
      meas_width_reg  <= '0;
      meas_height_reg <= '0;
    end else begin
      state_reg       <= state_next;
      col_reg         <= col_next;
      row_reg         <= row_next;
      line_base_reg   <= line_base_next;
      fb_we_reg       <= fb_we_next;
      fb_waddr_reg    <= fb_waddr_next;
      fb_wdata_reg    <= fb_wdata_next;
      frame_error_reg <= frame_error_next;
      meas_width_reg  <= meas_width_next;
      meas_height_reg <= meas_height_next;
    end
  end

`ifdef VGA_FRAME_CAPTURE_CRC_EN
  logic [15:0] crc_reg;

  // Runs one cycle behind the write port, so it settles long before the closing frame edge.
  always_ff @(posedge pixel_clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      crc_reg <= 16'h0000;
    end else if (state_reg == CAP_IDLE && capture_start) begin
      crc_reg <= CRC16_INIT;
    end else if (fb_we_reg) begin
      crc_reg <= crc16_ccitt_bit(crc_reg, fb_wdata_reg);
    end
  end

  assign crc_o = crc_reg;
`else
  assign crc_o = 16'h0000;
`endif

  assign fb_we       = fb_we_reg;
  assign fb_waddr    = fb_waddr_reg;
  assign fb_wdata    = fb_wdata_reg;
  assign busy        = (state_reg == CAP_ARMED) || (state_reg == CAP_CAPTURE);
  assign done        = (state_reg == CAP_DONE);
  assign frame_error = frame_error_reg;
  assign meas_width  = meas_width_reg;
  assign meas_height = meas_height_reg;

endmodule

// File: tb/tb_vga_frame_capture.sv
// Directed bench for vga_frame_capture on a reduced 8x6 raster with a small
// timing generator; a negedge monitor gathers write-port statistics.
module tb_vga_frame_capture;

  localparam int H   = 8;
  localparam int V   = 6;
  localparam int HFP = 2;
  localparam int HS  = 3;
  localparam int HT  = 16;
  localparam int VFP = 1;
  localparam int VS  = 2;
  localparam int VT  = 11;

  logic        pixel_clk = 1'b0;
  logic        wb_rst_i;
  logic        capture_start;
  logic        hsync, vsync, video_on;
  logic [7:0]  red, green, blue;
  logic [23:0] fg_color;
  logic        fb_we;
  logic [18:0] fb_waddr;
  logic        fb_wdata;
  logic        busy, done, frame_error;
  logic [10:0] meas_width;
  logic [9:0]  meas_height;
  logic [15:0] crc_o;

  vga_frame_capture #(
    .H_ACTIVE(H),
    .V_ACTIVE(V),
    .RGB_DEPTH(8),
    .SYNC_ACTIVE_LOW(1'b1)
  ) dut (
    .pixel_clk    (pixel_clk),
    .wb_rst_i     (wb_rst_i),
    .capture_start(capture_start),
    .hsync        (hsync),
    .vsync        (vsync),
    .video_on     (video_on),
    .red          (red),
    .green        (green),
    .blue         (blue),
    .fg_color     (fg_color),
    .fb_we        (fb_we),
    .fb_waddr     (fb_waddr),
    .fb_wdata     (fb_wdata),
    .busy         (busy),
    .done         (done),
    .frame_error  (frame_error),
    .meas_width   (meas_width),
    .meas_height  (meas_height),
    .crc_o        (crc_o)
  );

  always #5 pixel_clk = ~pixel_clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int mark_cyc = 0;

  int we_count, ones, order_bad, done_count, one_addr, one_cyc, exp_addr;
  bit saw_short;

  always @(posedge pixel_clk) cyc <= cyc + 1;

  // Statistics restart whenever an accepted arm pulse is seen.
  always @(negedge pixel_clk) begin
    if (capture_start && !busy) begin
      we_count = 0; ones = 0; order_bad = 0; done_count = 0;
      one_addr = -1; one_cyc = -1; exp_addr = 0; saw_short = 0;
    end
    if (fb_we) begin
      if (int'(fb_waddr) != exp_addr) order_bad++;
      exp_addr++;
      we_count++;
      if (fb_wdata) begin
        ones++;
        one_addr = int'(fb_waddr);
        one_cyc  = cyc;
      end
    end
    if (done) done_count++;
    if (busy && meas_width == 11'(H - 1)) saw_short = 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

`ifdef VGA_FRAME_CAPTURE_CRC_EN
  function automatic logic [15:0] crc_model(input int nbits, input bit b);
    logic [15:0] c;
    c = 16'hFFFF;
    for (int i = 0; i < nbits; i++) begin
      if (c[15] ^ b) c = {c[14:0], 1'b0} ^ 16'h1021;
      else           c = {c[14:0], 1'b0};
    end
    return c;
  endfunction
`endif

  task automatic pulse_start();
    capture_start = 1'b1;
    @(posedge pixel_clk); #1;
    capture_start = 1'b0;
  endtask

  // mode 0: all foreground, 1: only (5,2) foreground, 2: all black.
  task automatic drive_frame(input int mode, input int nlines, input int short_row,
                             input int short_w, input int start_row, input int abort_row);
    for (int v = 0; v < VT; v++) begin
      for (int h = 0; h < HT; h++) begin
        int  w;
        bit  act, fg;
        w   = (v == short_row) ? short_w : H;
        act = (v < nlines) && (h < w);
        fg  = (mode == 0) || (mode == 1 && v == 2 && h == 5);
        video_on = act;
        {red, green, blue} = (act && fg) ? fg_color : 24'h000000;
        hsync = !(h >= H + HFP && h < H + HFP + HS);
        vsync = !(v >= V + VFP && v < V + VFP + VS);
        capture_start = (v == start_row && h == 0);
        if (mode == 1 && act && fg) mark_cyc = cyc;
        if (v == abort_row && h == 4) begin
          check("abort_pre_busy", 32'(busy), 32'd1);
          check("abort_pre_we", 32'(fb_we), 32'd1);
          wb_rst_i = 1'b1;
          #1;
          check("abort_busy", 32'(busy), 32'd0);
          check("abort_we", 32'(fb_we), 32'd0);
        end else begin
          wb_rst_i = 1'b0;
        end
        @(posedge pixel_clk); #1;
      end
    end
    wb_rst_i = 1'b0;
    capture_start = 1'b0;
  endtask

  initial begin
    wb_rst_i = 1'b1;
    capture_start = 1'b0;
    hsync = 1'b1; vsync = 1'b1; video_on = 1'b0;
    red = 8'h00; green = 8'h00; blue = 8'h00;
    fg_color = 24'h00FF00;
    repeat (3) @(posedge pixel_clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_we", 32'(fb_we), 32'd0);
    check("rst_waddr", 32'(fb_waddr), 32'd0);
    check("rst_err", 32'(frame_error), 32'd0);
    check("rst_width", 32'(meas_width), 32'd0);
    check("rst_height", 32'(meas_height), 32'd0);
    check("rst_crc", 32'(crc_o), 32'd0);
    wb_rst_i = 1'b0;
    repeat (2) @(posedge pixel_clk);
    #1;

    // Full frame of foreground pixels.
    pulse_start();
    check("arm_busy", 32'(busy), 32'd1);
    drive_frame(0, V, -1, H, -1, -1);
    drive_frame(0, V, -1, H, -1, -1);
    check("full_we_count", 32'(we_count), 32'(H * V));
    check("full_order", 32'(order_bad), 32'd0);
    check("full_ones", 32'(ones), 32'(H * V));
    check("full_done", 32'(done_count), 32'd1);
    check("full_width", 32'(meas_width), 32'(H));
    check("full_height", 32'(meas_height), 32'(V));
    check("full_err", 32'(frame_error), 32'd0);
    check("full_busy", 32'(busy), 32'd0);
`ifdef VGA_FRAME_CAPTURE_CRC_EN
    check("full_crc", 32'(crc_o), 32'(crc_model(H * V, 1'b1)));
`else
    check("full_crc", 32'(crc_o), 32'd0);
`endif

    // Reset in the middle of row 3, then a normal capture.
    pulse_start();
    drive_frame(0, V, -1, H, -1, -1);
    drive_frame(0, V, -1, H, -1, 3);
    check("abort_done", 32'(done_count), 32'd0);
    check("abort_idle", 32'(busy), 32'd0);
    pulse_start();
    drive_frame(0, V, -1, H, -1, -1);
    drive_frame(0, V, -1, H, -1, -1);
    check("recap_done", 32'(done_count), 32'd1);
    check("recap_we_count", 32'(we_count), 32'(H * V));
    check("recap_height", 32'(meas_height), 32'(V));
    check("recap_err", 32'(frame_error), 32'd0);

    // Single foreground pixel at (5,2).
    pulse_start();
    drive_frame(1, V, -1, H, -1, -1);
    drive_frame(1, V, -1, H, -1, -1);
    check("dot_ones", 32'(ones), 32'd1);
    check("dot_addr", 32'(one_addr), 32'(2 * H + 5));
    check("dot_latency", 32'(one_cyc - mark_cyc), 32'd2);
    check("dot_we_count", 32'(we_count), 32'(H * V));
    check("dot_err", 32'(frame_error), 32'd0);

    // All-black frame with a stray arm pulse during capture.
    pulse_start();
    drive_frame(2, V, -1, H, -1, -1);
    drive_frame(2, V, -1, H, 3, -1);
    check("zero_done", 32'(done_count), 32'd1);
    check("zero_ones", 32'(ones), 32'd0);
    check("zero_we_count", 32'(we_count), 32'(H * V));
    check("zero_err", 32'(frame_error), 32'd0);
`ifdef VGA_FRAME_CAPTURE_CRC_EN
    check("zero_crc", 32'(crc_o), 32'(crc_model(H * V, 1'b0)));
`else
    check("zero_crc", 32'(crc_o), 32'd0);
`endif

    // Row 2 one pixel short.
    pulse_start();
    drive_frame(0, V, -1, H, -1, -1);
    drive_frame(0, V, 2, H - 1, -1, -1);
    check("short_seen", 32'(saw_short), 32'd1);
    check("short_err", 32'(frame_error), 32'd1);
    check("short_we_count", 32'(we_count), 32'(H * V - 1));
    check("short_done", 32'(done_count), 32'd1);

    // Frame truncated by one line.
    pulse_start();
    drive_frame(0, V, -1, H, -1, -1);
    drive_frame(0, V - 1, -1, H, -1, -1);
    check("trunc_height", 32'(meas_height), 32'(V - 1));
    check("trunc_err", 32'(frame_error), 32'd1);
    check("trunc_width", 32'(meas_width), 32'(H));
    check("trunc_done", 32'(done_count), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_frame_capture.md
Name: vga_frame_capture

Overview:
- Sink-side counterpart to the VGA character display path. Monitors a 640x480 VGA stream (hsync, vsync, video_on, 24-bit RGB) and recovers pixel coordinates from the sync and blanking signals.
- Converts each active pixel to 1 bit by comparing it against a foreground colour, then writes one captured frame into a 1-bit framebuffer write port.
- Used for loopback self-test of the display pipeline and for frame readback by software via a wrapper.

Parameters:
- H_ACTIVE, 640, active pixels per line.
- V_ACTIVE, 480, active lines per frame.
- RGB_DEPTH, 8, bits per colour channel.
- SYNC_ACTIVE_LOW, 1, 1 = hsync/vsync asserted low; 0 = asserted high.

Ports:
- pixel_clk  in  1  pixel clock (25 MHz)
- wb_rst_i  in  1  reset, asynchronous, active-high
- capture_start  in  1  single-cycle arm pulse
- hsync  in  1  horizontal sync from the timing generator
- vsync  in  1  vertical sync
- video_on  in  1  active-video qualifier
- red / green / blue  in  RGB_DEPTH each  pixel colour
- fg_color  in  3*RGB_DEPTH  foreground colour {R,G,B}; a pixel matching it exactly captures as 1
- fb_we  out  1  framebuffer write enable
- fb_waddr  out  19  framebuffer write address
- fb_wdata  out  1  captured pixel bit
- busy  out  1  high in ARMED or CAPTURE
- done  out  1  one-cycle pulse at end of capture
- frame_error  out  1  sticky geometry error for the last capture
- meas_width  out  11  length in pixels of the last completed active line
- meas_height  out  10  active line count of the last capture
- crc_o  out  16  CRC of the captured bits (see Optional Feature)

Behaviour:
- Reset (wb_rst_i, asynchronous, active-high; clock pixel_clk): state=IDLE; every output and counter = 0.
- Input stage: hsync, vsync, video_on and RGB are registered once (stage 1). Edge detection uses the stage 1 value and the previous stage 1 value.
- vsync_act = vsync XOR SYNC_ACTIVE_LOW. The frame edge is the inactive-to-active transition of vsync_act.
- FSM:
  - IDLE: on capture_start -> ARMED; clear frame_error, meas_*, crc.
  - ARMED: on frame edge -> CAPTURE; col=0, row=0.
  - CAPTURE:
    - On the next frame edge: if meas_height != V_ACTIVE, set frame_error; -> DONE.
    - Also exit with error if row reaches 512 (run-away guard).
  - DONE: done=1 for one cycle -> IDLE.
- capture_start while not IDLE is ignored.
- Pixel path (CAPTURE only, stage 1 video_on=1):
  - bit = ({R,G,B} == fg_color).
  - If col < H_ACTIVE and row < V_ACTIVE: fb_we=1, fb_waddr = row*H_ACTIVE + col (19-bit unsigned), fb_wdata = bit.
  - Otherwise no write, and frame_error is set.
  - col increments, saturating at 2047.
- Latency: a pixel on the inputs at edge N appears on fb_* after edge N+2. fb_we is registered and defaults to 0 every cycle.
- Line end (falling edge of stage 1 video_on, CAPTURE only):
  - meas_width <= col; set frame_error if col != H_ACTIVE.
  - row++; meas_height <= row+1; col <= 0.
- hsync is used only for error checking: an hsync_act assertion while video_on=1 sets frame_error.
- If the frame edge and a video_on falling edge coincide, process the line end first, then the height check on the updated count.
- Reset mid-capture aborts immediately. No done pulse; fb_we=0 at once.
- frame_error, meas_*, crc_o hold their values until the next capture_start.

Optional Feature:
- Macro VGA_FRAME_CAPTURE_CRC_EN.
- Defined: CRC-16-CCITT (poly 0x1021, init 0xFFFF, MSB-first, no final XOR) is updated with fb_wdata on every fb_we cycle. crc_o holds the running value and is final when done pulses.
- Undefined: no CRC logic; crc_o tied to 16'h0000.

Decomposition:
- Package vga_pkg holds:
  - H_ACTIVE_DEF=640, V_ACTIVE_DEF=480, FB_AW=19.
  - capture_state_t enum {CAP_IDLE, CAP_ARMED, CAP_CAPTURE, CAP_DONE}.
  - CRC16_POLY=16'h1021, CRC16_INIT=16'hFFFF.
- One sub-module, vga_sync_edge: registers the sync inputs, applies polarity and emits single-cycle rise/fall strobes for vsync_act, hsync_act and video_on.
- The CRC is a function in vga_pkg.

Test Plan:
- Reset mid-capture (at row 100): busy=0, fb_we=0 immediately; no done pulse; a following capture_start works normally.
- Drive standard 640x480@60 timing from the dtg, all pixels = fg_color 0x00FF00, then pulse capture_start:
  - Exactly 307200 fb_we pulses; addresses run 0..307199 in order; all fb_wdata=1.
  - done pulses once; meas_width=640, meas_height=480, frame_error=0.
- Same timing with pixel (col 5, row 2) = fg_color and all others 0x000000: only the write to fb_waddr=1285 carries fb_wdata=1; its fb_we occurs 2 cycles after that pixel's input.
- One line shortened to 639 active pixels: meas_width=639 is observed mid-frame; frame_error=1 at done.
- Frame truncated to 479 lines: meas_height=479 and frame_error=1.
- capture_start pulsed during CAPTURE: ignored; only one done pulse.
- With CRC_EN: an all-zero frame gives crc_o equal to a golden model computed over 307200 zero bits. Without CRC_EN: crc_o=0.
